acc_bcd_display: RTL and testbench
==================================

# acc_bcd_display

Display stage downstream of the 8-bit accumulator. It watches the accumulator's `d_out` value, converts each new value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low 3-digit 7-segment display with leading-zero blanking. It lets accumulator lab runs on the board show the running total in decimal.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit is enabled during display scan; legal values ≥1.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `acc_in`  in  8  unsigned value from the accumulator's `d_out`.
- `bcd`  out  12  {hundreds, tens, ones} BCD of the last completed conversion.
- `bcd_valid`  out  1  high when `bcd` matches the last sampled `acc_in`.
- `busy`  out  1  high while a conversion is in progress.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an_n`  out  3  digit enables {hundreds, tens, ones}, active-low one-hot, registered.

## Operation
- **State machine:** two states, IDLE and CONV.
- **Reset values:**
  - state IDLE, `last_val`=0, `bcd`=12'h000, `bcd_valid`=1, `busy`=0.
  - Scan counter 0, digit index 0 (ones), `an_n`=3'b110, `seg_n`=7'b1000000.
- **IDLE:** if `acc_in` ≠ `last_val`:
  - load `acc_in` into the binary shift register and into `last_val`;
  - clear the BCD work register and the iteration counter;
  - set `busy`=1 and `bcd_valid`=0;
  - go to CONV.
  - Otherwise hold.
- **CONV:** one iteration per cycle, 8 iterations.
  - Each iteration: add 3 to every work nibble ≥5, then shift {work, bin} left by 1.
  - After the 8th iteration: `bcd` ← work result, `bcd_valid`=1, `busy`=0, go to IDLE.
- **acc_in changes during CONV:** ignored. `last_val` holds the value being converted, so any newer value is detected on the first IDLE cycle after the conversion.
- **Range:** max input 255, so the hundreds digit is ≤2. No overflow is possible.
- **Display source:** the display always uses the `bcd` register. During a conversion it keeps showing the previous result.
- **Scan sequencing:**
  - The scan counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index advances 0→1→2→0 (ones→tens→hundreds).
  - Scanning is independent of conversion state.
- **Digit enables:** `an_n` is low only for the current digit (3'b110 ones, 3'b101 tens, 3'b011 hundreds).
- **Segment encoding:** 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000. Any other nibble gives 1111111.
- **Leading-zero blanking:**
  - Hundreds is blanked (`seg_n`=1111111) when it is 0.
  - Tens is blanked when both hundreds and tens are 0.
  - Ones is never blanked.
  - `an_n` still asserts for a blanked digit.
- **Reset mid-conversion:** aborts the conversion. All registers return to reset values on that edge, and no partial result reaches `bcd`.

## Timing
- `acc_in` change stable before edge k: load at edge k, so `busy`=1 and `bcd_valid`=0 after k.
- Iterations occur at edges k+1..k+8. `bcd` updates, `bcd_valid`=1 and `busy`=0 after edge k+8.
- Earliest next load is edge k+9. Minimum spacing between loads is 9 cycles.
- `an_n`/`seg_n` are registered: they reflect the digit index and `bcd` one edge after those change.
- A new `bcd` appears on the display ≤1 cycle after it is written.
- Each digit is enabled for exactly SCAN_DIV cycles. A full scan period is 3·SCAN_DIV cycles.

## Test plan
- Reset held 2 cycles, `acc_in`=0 → `bcd`=12'h000, `bcd_valid`=1, `busy`=0, `an_n`=110, `seg_n`=1000000. No conversion starts after release.
- `acc_in` 0→173 before edge k → `busy` high for edges k..k+7. `bcd`=12'h173 and `bcd_valid`=1 after k+8.
- `acc_in`=255, then 0 (accumulator wrap) → `bcd`=12'h255, then 12'h000. For 100 → 12'h100 with the tens '0' shown (`seg_n` 1000000, not blanked).
- `acc_in`=7, SCAN_DIV=4 → hundreds and tens slots show `seg_n`=1111111, ones slot shows 1111000. Each `an_n` value is held 4 cycles, period 12.
- `acc_in`=50, changed to 60 at load+3 → `bcd`=12'h050 after load+8, reload at load+9, `bcd`=12'h060 after load+17.
- `rst_n` low at load+4 during conversion of 200 → `bcd`=12'h000, `bcd_valid`=1, `busy`=0. After release with `acc_in`=200, a fresh conversion gives 12'h200.

Source files
------------

// File: rtl/acc_bcd_display.sv
// Display stage for the 8-bit accumulator: converts each new acc_in value to
// three BCD digits with a sequential double-dabble engine and drives a
// time-multiplexed, active-low 3-digit 7-segment display with leading-zero
// blanking.
module acc_bcd_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  acc_in,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n
);

    localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned ITER_W = 4;
    localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(7);
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          last_val_q, last_val_d;
    logic [7:0]          bin_q, bin_d;
    logic [11:0]         work_q, work_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [11:0]         bcd_q, bcd_d;
    logic                bcd_valid_q, bcd_valid_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    scan_q, scan_d;
    logic [1:0]          digit_q, digit_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic [2:0]          an_n_q, an_n_d;

    // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
    function automatic logic [11:0] dabble_adjust(input logic [11:0] w);
        logic [11:0] r;
        r = w;
        for (int i = 0; i < 3; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on a new value, return after the 8th iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_in != last_val_q) state_d = CONV;
            CONV:    if (iter_q == ITER_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath and status outputs.
    always_comb begin
        logic [11:0] adj;
        last_val_d  = last_val_q;
        bin_d       = bin_q;
        work_d      = work_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        busy_d      = busy_q;
        adj         = dabble_adjust(work_q);
        case (state_q)
            IDLE: begin
                if (acc_in != last_val_q) begin
                    last_val_d  = acc_in;
                    bin_d       = acc_in;
                    work_d      = 12'h000;
                    iter_d      = '0;
                    busy_d      = 1'b1;
                    bcd_valid_d = 1'b0;
                end
            end
            CONV: begin
                // Shift {work, bin} left by one; top work bit is always zero for 8-bit input.
                work_d = 12'({adj, bin_q[7]});
                bin_d  = {bin_q[6:0], 1'b0};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    bcd_d       = 12'({adj, bin_q[7]});
                    bcd_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Display scan: digit index advances every SCAN_DIV cycles, ones->tens->hundreds.
    always_comb begin
        scan_d  = scan_q + CNT_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
    end

    // Segment and anode drive for the current digit with leading-zero blanking.
    always_comb begin
        an_n_d  = 3'b110;
        seg_n_d = seg_encode(bcd_q[3:0]);
        case (digit_q)
            2'd1: begin
                an_n_d  = 3'b101;
                seg_n_d = (bcd_q[11:4] == 8'h00) ? SEG_BLANK : seg_encode(bcd_q[7:4]);
            end
            2'd2: begin
                an_n_d  = 3'b011;
                seg_n_d = (bcd_q[11:8] == 4'h0) ? SEG_BLANK : seg_encode(bcd_q[11:8]);
            end
            default: ;
        endcase
    end

    // Datapath and display registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            last_val_q  <= 8'h00;
            bin_q       <= 8'h00;
            work_q      <= 12'h000;
            iter_q      <= '0;
            bcd_q       <= 12'h000;
            bcd_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            scan_q      <= '0;
            digit_q     <= 2'd0;
            an_n_q      <= 3'b110;
            seg_n_q     <= 7'b1000000;
        end else begin
            last_val_q  <= last_val_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q      <= busy_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            an_n_q      <= an_n_d;
            seg_n_q     <= seg_n_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = busy_q;
    assign seg_n     = seg_n_q;
    assign an_n      = an_n_q;

endmodule

// File: tb/tb_acc_bcd_display.sv
// Bench for acc_bcd_display: stimulus pushes expected BCD results into a queue,
// a monitor pops one per completed conversion; display scan checked directly.
module tb_acc_bcd_display;

    localparam int unsigned SCAN_DIV = 4;

    logic        clock;
    logic        rst_n;
    logic [7:0]  acc_in;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [6:0]  seg_n;
    logic [2:0]  an_n;

    int n_pass  = 0;
    int n_total = 0;
    int model_last = 0;
    logic [11:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    acc_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .acc_in    (acc_in),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Change acc_in; a differing value will be converted, so its result is expected.
    task automatic drive(input int v);
        acc_in = 8'(v);
        if (v != model_last) begin
            exp_q.push_back(to_bcd(v));
            model_last = v;
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        tick();
        for (int i = 0; i < 30; i++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) begin
            n_total++;
            $display("FAIL wait_idle: busy still %0b after 30 cycles, expected 0", busy);
        end
    endtask

    // Watch two scan periods and check every sampled digit against the value's decimal form.
    task automatic check_display(input int v);
        int dig[3];
        int idx, prev_idx, run;
        bit first;
        logic [6:0] exp_seg;
        logic [2:0] prev_an;
        dig[0] = v % 10;
        dig[1] = (v / 10) % 10;
        dig[2] = v / 100;
        tick();
        prev_an  = an_n;
        prev_idx = -1;
        run      = 0;
        first    = 1;
        for (int c = 0; c < 6 * SCAN_DIV; c++) begin
            tick();
            case (an_n)
                3'b110:  idx = 0;
                3'b101:  idx = 1;
                3'b011:  idx = 2;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                chk("an_n_onehot", 32'(an_n), 32'h6);
                continue;
            end
            exp_seg = seg_tab[dig[idx]];
            if (idx == 2 && dig[2] == 0) exp_seg = 7'b1111111;
            if (idx == 1 && dig[2] == 0 && dig[1] == 0) exp_seg = 7'b1111111;
            chk($sformatf("seg_n v=%0d digit=%0d", v, idx), 32'(seg_n), 32'(exp_seg));
            if (an_n == prev_an) begin
                run++;
            end else begin
                if (!first) chk("an_n_hold_cycles", 32'(run), 32'(SCAN_DIV));
                if (prev_idx >= 0) chk("scan_order", 32'(idx), 32'((prev_idx + 1) % 3));
                first = 0;
                run   = 1;
            end
            prev_an  = an_n;
            prev_idx = idx;
        end
    endtask

    // Monitor: one expected result per completed conversion (bcd_valid rising outside reset).
    initial begin
        logic prev_valid;
        logic rst_at_edge;
        logic [11:0] e;
        prev_valid = 1'b1;
        forever begin
            @(posedge clock);
            rst_at_edge = rst_n;
            #1;
            if (rst_at_edge && bcd_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: bcd=%03h with no pending expectation", bcd);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_bcd", 32'(bcd), 32'(e));
                end
            end
            prev_valid = bcd_valid;
        end
    end

    initial begin
        bit all_busy;
        int v;
        rst_n  = 1'b0;
        acc_in = 8'd0;
        tick();
        tick();
        chk("reset_bcd", 32'(bcd), 32'h000);
        chk("reset_valid", 32'(bcd_valid), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_an_n", 32'(an_n), 32'h6);
        chk("reset_seg_n", 32'(seg_n), 32'h40);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("no_conv_after_reset", 32'(busy), 32'h0);

        // 0 -> 173 with exact latency.
        drive(173);
        tick();
        chk("load_busy", 32'(busy), 32'h1);
        chk("load_valid", 32'(bcd_valid), 32'h0);
        all_busy = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (!busy) all_busy = 0;
        end
        chk("busy_through_k7", 32'(all_busy), 32'h1);
        tick();
        chk("done_busy", 32'(busy), 32'h0);
        chk("done_valid", 32'(bcd_valid), 32'h1);
        chk("done_bcd_173", 32'(bcd), 32'h173);
        check_display(173);

        // Accumulator wrap 255 -> 0, then 100 (tens zero shown) and 7 (blanking).
        drive(255); wait_idle(); check_display(255);
        drive(0);   wait_idle(); check_display(0);
        drive(100); wait_idle(); check_display(100);
        drive(7);   wait_idle(); check_display(7);

        // Value changes mid-conversion: 50 finishes, then 60 reloads at load+9.
        tick();
        drive(50);
        tick(); tick(); tick();
        drive(60);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_first_valid", 32'(bcd_valid), 32'h1);
        chk("mid_first_bcd", 32'(bcd), 32'h050);
        tick();
        chk("mid_reload_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_second_valid", 32'(bcd_valid), 32'h1);
        chk("mid_second_bcd", 32'(bcd), 32'h060);

        // Reset during conversion of 200 discards the partial result.
        tick();
        acc_in = 8'd200;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("abort_bcd", 32'(bcd), 32'h000);
        chk("abort_valid", 32'(bcd_valid), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        model_last = 0;
        rst_n = 1'b1;
        drive(200);
        wait_idle();
        tick();
        chk("after_abort_bcd", 32'(bcd), 32'h200);
        check_display(200);

        // Randomized values with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(0, 255));
            drive(v);
            wait_idle();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            if (i % 8 == 0) check_display(v);
        end

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
